alu_serial_adder_8b: RTL



---
 rtl/alu_serial_adder_8b_if.sv | 42 ++++
 rtl/alu_serial_adder_8b.sv | 126 ++++++++++++
 2 files changed

// File: rtl/alu_serial_adder_8b_if.sv
// Handshake and result bus of the bit-serial add/subtract stage.
// Optional carry_in signal is present only when ALU_SERIAL_CARRY_IN_EN is defined.
interface alu_serial_adder_8b_if #(
    parameter int WIDTH = 8
);
    // start is sampled on the clock edge and accepted only when busy is low.
    // done is a one-cycle pulse; result and flags stay valid until the next
    // done pulse or reset.
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
`ifdef ALU_SERIAL_CARRY_IN_EN
    logic             carry_in;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             zero_flag;
    logic             overflow;

`ifdef ALU_SERIAL_CARRY_IN_EN
    modport master (
        output start, op_sub, operand_a, operand_b, carry_in,
        input  busy, done, result, carry_out, zero_flag, overflow
    );
    modport slave (
        input  start, op_sub, operand_a, operand_b, carry_in,
        output busy, done, result, carry_out, zero_flag, overflow
    );
`else
    modport master (
        output start, op_sub, operand_a, operand_b,
        input  busy, done, result, carry_out, zero_flag, overflow
    );
    modport slave (
        input  start, op_sub, operand_a, operand_b,
        output busy, done, result, carry_out, zero_flag, overflow
    );
`endif
endinterface

// File: rtl/alu_serial_adder_8b.sv
// Bit-serial LSB-first add/subtract with C/Z/V flags and start/done handshake.
// Define ALU_SERIAL_CARRY_IN_EN to add a carry_in input (ADC/SBC semantics).
module alu_half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module alu_serial_adder_8b #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4   // 2**CNT_W must exceed WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_serial_adder_8b_if.slave bus,
    output logic [1:0]           state_dbg
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] sh_a_q, sh_b_q, acc_q;
    logic             carry_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_out_q, zero_q, overflow_q;

    logic             p_bit, g_bit, s_bit, t_bit, c_next;
    logic             last_bit, start_ok, carry_init, c_msb_in;
    logic [WIDTH-1:0] sum_word;

    // Full adder built from two half adders plus an OR.
    alu_half_adder u_ha0 (
        .a     (sh_a_q[0]),
        .b     (sh_b_q[0]),
        .sum   (p_bit),
        .carry (g_bit)
    );

    alu_half_adder u_ha1 (
        .a     (p_bit),
        .b     (carry_q),
        .sum   (s_bit),
        .carry (t_bit)
    );

    assign c_next   = g_bit | t_bit;
    assign last_bit = (count_q == CNT_W'(WIDTH - 1));
    assign start_ok = bus.start && (state_q != S_RUN);
    assign sum_word = {s_bit, acc_q[WIDTH-1:1]};
    // On the last bit the registered carry is the carry into the MSB.
    assign c_msb_in = carry_q;

`ifdef ALU_SERIAL_CARRY_IN_EN
    assign carry_init = bus.carry_in;
`else
    assign carry_init = bus.op_sub;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.start) state_d = S_RUN;
            S_RUN:  if (last_bit)  state_d = S_DONE;
            S_DONE: state_d = bus.start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: capture on accepted start, one bit per edge while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            count_q     <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (start_ok) begin
            sh_a_q  <= bus.operand_a;
            sh_b_q  <= bus.op_sub ? ~bus.operand_b : bus.operand_b;
            acc_q   <= '0;
            carry_q <= carry_init;
            count_q <= '0;
        end else if (state_q == S_RUN) begin
            sh_a_q  <= {1'b0, sh_a_q[WIDTH-1:1]};
            sh_b_q  <= {1'b0, sh_b_q[WIDTH-1:1]};
            acc_q   <= sum_word;
            carry_q <= c_next;
            count_q <= count_q + CNT_W'(1);
            if (last_bit) begin
                result_q    <= sum_word;
                carry_out_q <= c_next;
                overflow_q  <= c_msb_in ^ c_next;
                zero_q      <= (sum_word == '0);
            end
        end
    end

    assign bus.busy      = (state_q == S_RUN);
    assign bus.done      = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.carry_out = carry_out_q;
    assign bus.zero_flag = zero_q;
    assign bus.overflow  = overflow_q;
    assign state_dbg     = state_q;
endmodule
